// File: rtl/ctr_mode_sched_pkg.sv
// Shared CryptoCore definitions for the CTR-mode block scheduler:
// default widths, FSM state encodings and counter control bundle.
package ctr_mode_sched_pkg;

  localparam int CC_W     = 64;
  localparam int CC_N     = 2;
  localparam int CC_LEN_W = 16;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
  localparam logic [ST_W-1:0] ST_ISSUE = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd3;
  localparam logic [ST_W-1:0] ST_FIN   = 3'd4;

  typedef struct packed {
    logic load;
    logic en;
  } ctr_ctl_t;

  function automatic logic st_busy(input logic [ST_W-1:0] s);
    return (s == ST_LOAD) || (s == ST_ISSUE) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/ctr_mode_sched_counter_rollover.sv
// W-bit counter split into N cascaded segments; a segment advances when
// enabled and every lower segment is all-ones. Contents are not reset.
module counter_rollover #(
  parameter int W = 64,
  parameter int N = 2
) (
  input  logic         CLK,
  input  logic         LOAD,
  input  logic         ENABLE,
  input  logic [W-1:0] DI,
  output logic [W-1:0] DO
);

  localparam int SW = W / N;

  logic [N-1:0][SW-1:0] seg;
  logic [N-1:0]         carry;

  assign carry[0] = ENABLE;
  for (genvar i = 1; i < N; i++) begin : g_carry
    assign carry[i] = ENABLE & (&seg[i-1:0]);
  end

  always_ff @(posedge CLK) begin
    if (LOAD) seg <= DI;
    else begin
      for (int i = 0; i < N; i++)
        if (carry[i]) seg[i] <= seg[i] + 1'b1;
    end
  end

  assign DO = seg;

endmodule

// File: rtl/ctr_mode_sched.sv
// CTR-mode session scheduler: loads an IV into the rollover counter and
// offers NBLK successive counter values to a cipher core, one at a time.
module ctr_mode_sched
  import ctr_mode_sched_pkg::*;
#(
  parameter int W          = CC_W,
  parameter int N          = CC_N,
  parameter int LEN_W      = CC_LEN_W,
  parameter int ALLOW_WRAP = 0
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             START,
  input  logic             ABORT,
  input  logic [W-1:0]     IV,
  input  logic [LEN_W-1:0] NBLK,
  output logic             CORE_VALID,
  input  logic             CORE_READY,
  output logic [W-1:0]     CORE_DATA,
  input  logic             CORE_DONE,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [LEN_W-1:0] BLK_IDX
);

  logic [ST_W-1:0]  state, state_nx;
  logic [LEN_W-1:0] rem;
  logic             wrap_pend;
  logic             hs, accept;
  ctr_ctl_t         ctl;

  assign CORE_VALID = (state == ST_ISSUE) && !ABORT;
  assign hs         = CORE_VALID && CORE_READY;
  assign accept     = (state == ST_IDLE) && START && !ABORT;
  assign ctl        = '{load: (state == ST_LOAD), en: hs};

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = (NBLK != '0) ? ST_LOAD : ST_FIN;
      ST_LOAD:  state_nx = ST_ISSUE;
      ST_ISSUE: if (hs) state_nx = ST_WAIT;
      ST_WAIT:  if (CORE_DONE) state_nx = (rem == '0 || wrap_pend) ? ST_FIN : ST_ISSUE;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (ABORT && state != ST_IDLE) state_nx = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      BLK_IDX   <= '0;
      rem       <= '0;
      wrap_pend <= 1'b0;
    end else begin
      state <= state_nx;
      BUSY  <= st_busy(state_nx);
      DONE  <= (state_nx == ST_FIN);
      if (accept) begin
        ERR       <= 1'b0;
        BLK_IDX   <= '0;
        rem       <= NBLK;
        wrap_pend <= 1'b0;
      end else if (hs) begin
        BLK_IDX <= BLK_IDX + 1'b1;
        rem     <= rem - 1'b1;
        // all-ones accepted with blocks still owed: the next value would wrap
        if (&CORE_DATA && rem != LEN_W'(1) && ALLOW_WRAP == 0) wrap_pend <= 1'b1;
      end else if (ABORT && state != ST_IDLE) begin
        wrap_pend <= 1'b0;
      end
      if (state == ST_WAIT && state_nx == ST_FIN && wrap_pend) ERR <= 1'b1;
    end
  end

  counter_rollover #(.W(W), .N(N)) u_ctr (
    .CLK    (CLK),
    .LOAD   (ctl.load),
    .ENABLE (ctl.en),
    .DI     (IV),
    .DO     (CORE_DATA)
  );

endmodule

// File: doc/ctr_mode_sched.md
CTR_MODE_SCHED -- requirements
Module: ctr_mode_sched

Interface
REQ-001 SHALL have parameter W, default 64, meaning counter/block width in bits.
REQ-002 SHALL have parameter N, default 2, meaning number of cascaded counter segments; W divisible by N.
REQ-003 SHALL have parameter LEN_W, default 16, meaning width of block-count fields.
REQ-004 SHALL have parameter ALLOW_WRAP, default 0, meaning 1 permits the counter to wrap within a session.
REQ-005 SHALL have ports: CLK  in  1  rising-edge clock; RSTn  in  1  asynchronous active-low reset. These are the block's only clock and reset.
REQ-006 SHALL have ports: START  in  1  session start pulse; ABORT  in  1  session kill; IV  in  W  initial counter value; NBLK  in  LEN_W  blocks to issue.
REQ-007 SHALL have ports: CORE_VALID  out  1  counter block offered to cipher core; CORE_READY  in  1  core accepts block; CORE_DATA  out  W  current counter value; CORE_DONE  in  1  core finished one block.
REQ-008 SHALL have ports: BUSY  out  1  session active; DONE  out  1  one-cycle completion pulse; ERR  out  1  sticky wrap error; BLK_IDX  out  LEN_W  blocks accepted this session.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, ISSUE, WAIT, FIN.
REQ-010 SHALL, in IDLE on START=1 with NBLK!=0, latch NBLK into a remaining register, clear ERR and BLK_IDX, and enter LOAD.
REQ-011 SHALL, in IDLE on START=1 with NBLK=0, enter FIN directly without loading the counter.
REQ-012 SHALL assert counter LOAD with data IV for exactly the LOAD cycle, then enter ISSUE; the first CORE_VALID appears 2 cycles after START.
REQ-013 SHALL drive CORE_VALID = (state==ISSUE) AND NOT ABORT, combinationally.
REQ-014 SHALL treat a handshake as CORE_VALID AND CORE_READY in the same cycle.
REQ-015 SHALL, on handshake, pulse counter ENABLE for one cycle, increment BLK_IDX, decrement remaining, and enter WAIT.
REQ-016 SHALL hold CORE_DATA stable while CORE_VALID is high and not accepted.
REQ-017 SHALL, in WAIT on CORE_DONE=1, enter FIN if remaining==0 or a wrap error is pending; otherwise re-enter ISSUE.
REQ-018 SHALL ignore CORE_DONE in every state except WAIT.
REQ-019 SHALL flag a pending wrap error when a handshake accepts CORE_DATA = all-ones, remaining after the decrement is non-zero, and ALLOW_WRAP=0; ERR then rises on entry to FIN.
REQ-020 SHALL, with ALLOW_WRAP=1, let the counter wrap from all-ones to zero and continue without error.
REQ-021 SHALL, in FIN, pulse DONE for one cycle and return to IDLE.
REQ-022 SHALL drive BUSY=1 in LOAD, ISSUE and WAIT, and BUSY=0 in IDLE and FIN (registered).
REQ-023 SHALL, on ABORT=1 in any non-IDLE state, return to IDLE next cycle with no DONE pulse and no ERR change.
REQ-024 SHALL give ABORT priority over START when both are asserted in IDLE, so the block stays in IDLE.
REQ-025 SHALL ignore START while not in IDLE.
REQ-026 SHALL hold ERR until the next accepted START.

Reset
REQ-027 SHALL, with RSTn=0, asynchronously force: state IDLE, BUSY 0, DONE 0, ERR 0, BLK_IDX 0, remaining 0, CORE_VALID 0, and no pending wrap error.
REQ-028 SHALL not reset the counter contents; CORE_DATA is don't-care while CORE_VALID=0.
REQ-029 SHALL, on reset asserted mid-session, discard the session; the core must be reset by its owner.

Structure
REQ-030 SHALL place FSM state encodings and default W/N/LEN_W constants in the shared CryptoCore package.
REQ-031 SHALL instantiate one counter_rollover (W, N), driving its LOAD/ENABLE/DI from the FSM and reading DO as CORE_DATA.

Verification
REQ-032 SHALL verify normal flow: IV=64'h0000_0000_0000_0010, NBLK=3, CORE_READY=1, CORE_DONE 2 cycles after each handshake -> CORE_DATA 0x10, 0x11, 0x12; DONE once; BLK_IDX=3; ERR=0.
REQ-033 SHALL verify backpressure: CORE_READY low 5 cycles -> CORE_VALID held and CORE_DATA stable; no BLK_IDX change until the handshake.
REQ-034 SHALL verify segment carry: IV=64'h0000_0000_FFFF_FFFF, NBLK=2 -> second block 64'h0000_0001_0000_0000.
REQ-035 SHALL verify wrap: IV=all-ones, NBLK=2, ALLOW_WRAP=0 -> one handshake, then FIN with ERR=1 and BLK_IDX=1. With ALLOW_WRAP=1 -> second block 0, ERR=0.
REQ-036 SHALL verify abort: ABORT in WAIT after block 1 of 4 -> IDLE next cycle, no DONE, BUSY=0; a new START then works.
REQ-037 SHALL verify edge cases: NBLK=0 -> DONE the cycle after START, no CORE_VALID. START+ABORT in IDLE -> no action. RSTn low mid-ISSUE -> all outputs at reset values immediately.
